// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder/channel/decoder path: streams payload plus zero tail bits,
// schedules channel error masks, and scores decoded bits against the stored payload.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 2,
  parameter int ERR_LOG2  = 4,
  parameter int TIMEOUT   = 512
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic                                    err_en_i,
  input  logic [1:0]                              err_pat_i,
  input  logic                                    src_valid_i,
  input  logic                                    src_bit_i,
  output logic                                    src_ready_o,
  output logic                                    enc_enable_o,
  output logic                                    enc_bit_o,
  output logic [1:0]                              err_mask_o,
  input  logic                                    dec_valid_i,
  input  logic                                    dec_bit_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    timeout_o,
  output logic [$clog2(FRAME_LEN+1)-1:0]          bit_err_o,
  output logic [$clog2(FRAME_LEN+TAIL_LEN+1)-1:0] inj_cnt_o
);

  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(FRAME_LEN + TAIL_LEN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] WR_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] RD_FULL  = IW'(FRAME_LEN);
  localparam logic [SW-1:0] SYM_LAST = SW'(FRAME_LEN + TAIL_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    TAIL,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic [SW-1:0]       sym_idx;
  logic [TW-1:0]       drain_cnt;
  logic                err_en;
  logic [1:0]          err_pat;
  logic [(1<<AW)-1:0]  payload;

  logic xfer;
  logic busy;
  logic inj_hit;
  logic score;
  logic mismatch;
  logic frame_start;
  logic timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    src_ready_o  = 1'b0;
    enc_enable_o = 1'b0;
    enc_bit_o    = 1'b0;
    frame_start  = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt   = PAYLOAD;
          frame_start = 1'b1;
        end
      end
      PAYLOAD: begin
        src_ready_o = 1'b1;
        if (src_valid_i) begin
          enc_enable_o = 1'b1;
          enc_bit_o    = src_bit_i;
          if (wr_idx == WR_LAST) begin
            state_nxt = (TAIL_LEN > 0) ? TAIL : DRAIN;
          end
        end
      end
      TAIL: begin
        enc_enable_o = 1'b1;
        if (sym_idx == SYM_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A completed frame wins over a timeout landing in the same cycle.
        if (rd_idx == RD_FULL) begin
          state_nxt = DONE;
        end else if (drain_cnt == TO_LAST) begin
          state_nxt   = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign xfer     = (state == PAYLOAD) & src_valid_i;
  assign busy     = (state == PAYLOAD) | (state == TAIL) | (state == DRAIN);
  assign inj_hit  = enc_enable_o & err_en & (&sym_idx[ERR_LOG2-1:0]);
  assign score    = busy & dec_valid_i & (rd_idx < wr_idx);
  assign mismatch = score & (dec_bit_i != payload[rd_idx[AW-1:0]]);

  assign err_mask_o = inj_hit ? err_pat : 2'b00;
  assign busy_o     = busy;
  assign done_o     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      sym_idx   <= '0;
      drain_cnt <= '0;
      err_en    <= 1'b0;
      err_pat   <= 2'b00;
      bit_err_o <= '0;
      inj_cnt_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (frame_start) begin
        wr_idx    <= '0;
        rd_idx    <= '0;
        sym_idx   <= '0;
        bit_err_o <= '0;
        inj_cnt_o <= '0;
        timeout_o <= 1'b0;
        err_en    <= err_en_i;
        err_pat   <= err_pat_i;
      end else begin
        if (xfer && wr_idx != '1) begin
          wr_idx <= wr_idx + 1'b1;
        end
        if (enc_enable_o && sym_idx != '1) begin
          sym_idx <= sym_idx + 1'b1;
        end
        if (score) begin
          rd_idx <= rd_idx + 1'b1;
        end
        if (mismatch && bit_err_o != '1) begin
          bit_err_o <= bit_err_o + 1'b1;
        end
        // A zero pattern leaves the channel untouched, so it is not counted as an injection.
        if (inj_hit && err_pat != 2'b00 && inj_cnt_o != '1) begin
          inj_cnt_o <= inj_cnt_o + 1'b1;
        end
        if (timeout_hit) begin
          timeout_o <= 1'b1;
        end
      end
      if (state != DRAIN) begin
        drain_cnt <= '0;
      end else if (drain_cnt != TO_LAST) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      payload[wr_idx[AW-1:0]] <= src_bit_i;
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl: a loopback decoder echoes encoder bits 20 cycles late.
module tb_viterbi_frame_ctrl;

  localparam int FL  = 64;
  localparam int TL  = 2;
  localparam int EL  = 4;
  localparam int TO  = 512;
  localparam int LAT = 20;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       err_en_i;
  logic [1:0] err_pat_i;
  logic       src_valid_i;
  logic       src_bit_i;
  logic       src_ready_o;
  logic       enc_enable_o;
  logic       enc_bit_o;
  logic [1:0] err_mask_o;
  logic       dec_valid_i;
  logic       dec_bit_i;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic [6:0] bit_err_o;
  logic [6:0] inj_cnt_o;

  int total;
  int bad;

  int o_n_en, o_en_bad, o_bit_bad, o_rdy_bad, o_mask_bad, o_inj;
  int o_done_cnt, o_done_cycle, o_first_en, o_last_en;
  logic o_busy1;

  logic hist_en  [0:2047];
  logic hist_bit [0:2047];
  int   hist_sym [0:2047];

  viterbi_frame_ctrl #(
    .FRAME_LEN(FL),
    .TAIL_LEN (TL),
    .ERR_LOG2 (EL),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .err_en_i    (err_en_i),
    .err_pat_i   (err_pat_i),
    .src_valid_i (src_valid_i),
    .src_bit_i   (src_bit_i),
    .src_ready_o (src_ready_o),
    .enc_enable_o(enc_enable_o),
    .enc_bit_o   (enc_bit_o),
    .err_mask_o  (err_mask_o),
    .dec_valid_i (dec_valid_i),
    .dec_bit_i   (dec_bit_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .bit_err_o   (bit_err_o),
    .inj_cnt_o   (inj_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic pay_bit(input int i);
    int v;
    v = i ^ (i >> 2) ^ (i >> 5);
    return v[0];
  endfunction

  // Cycle 0 requests the start; cycle 1 is the first PAYLOAD cycle.
  task automatic run_frame(input logic cfg_en, input logic [1:0] cfg_pat, input bit stall,
                           input int flip_a, input int flip_b, input int max_dec, input int start_at);
    int cyc, n_dec, post, exp_sym;
    logic exp_en, exp_rdy, exp_bit;
    logic [1:0] exp_mask;
    o_n_en = 0; o_en_bad = 0; o_bit_bad = 0; o_rdy_bad = 0; o_mask_bad = 0; o_inj = 0;
    o_done_cnt = 0; o_done_cycle = -1; o_first_en = 0; o_last_en = 0; o_busy1 = 1'b0;
    @(negedge clk);
    start_i = 1'b1; err_en_i = cfg_en; err_pat_i = cfg_pat;
    src_valid_i = 1'b0; dec_valid_i = 1'b0;
    cyc = 0; n_dec = 0; post = -1;
    while (cyc < 2000 && post != 0) begin
      @(negedge clk);
      cyc++;
      start_i     = (cyc == start_at);
      err_en_i    = ~cfg_en;
      err_pat_i   = ~cfg_pat;
      src_valid_i = stall ? (cyc % 2 == 1) : 1'b1;
      src_bit_i   = (o_n_en < FL) ? pay_bit(o_n_en) : 1'b1;
      if (cyc > LAT && hist_en[cyc-LAT] && n_dec < max_dec) begin
        dec_valid_i = 1'b1;
        dec_bit_i   = hist_bit[cyc-LAT] ^ (hist_sym[cyc-LAT] == flip_a || hist_sym[cyc-LAT] == flip_b);
        n_dec++;
      end else begin
        dec_valid_i = 1'b0;
        dec_bit_i   = 1'b0;
      end
      #1;
      if (cyc == 1) o_busy1 = busy_o;
      exp_sym = o_n_en;
      if (o_n_en < FL) begin
        exp_en = src_valid_i; exp_rdy = 1'b1; exp_bit = pay_bit(o_n_en);
      end else if (o_n_en < FL + TL) begin
        exp_en = 1'b1; exp_rdy = 1'b0; exp_bit = 1'b0;
      end else begin
        exp_en = 1'b0; exp_rdy = 1'b0; exp_bit = 1'b0;
      end
      exp_mask = (exp_en && cfg_en && (exp_sym % (1 << EL) == (1 << EL) - 1)) ? cfg_pat : 2'b00;
      if (enc_enable_o !== exp_en) o_en_bad++;
      if (exp_en && enc_bit_o !== exp_bit) o_bit_bad++;
      if (o_n_en < FL + TL && src_ready_o !== exp_rdy) o_rdy_bad++;
      if (err_mask_o !== exp_mask) o_mask_bad++;
      if (enc_enable_o === 1'b1) begin
        if (o_first_en == 0) o_first_en = cyc;
        o_last_en = cyc;
        if (err_mask_o !== 2'b00) o_inj++;
      end
      hist_en[cyc]  = exp_en;
      hist_bit[cyc] = exp_bit;
      hist_sym[cyc] = exp_sym;
      if (exp_en) o_n_en++;
      if (post > 0) post--;
      if (done_o === 1'b1) begin
        if (o_done_cnt == 0) begin
          o_done_cycle = cyc;
          post = 3;
        end
        o_done_cnt++;
      end
    end
    start_i = 1'b0; src_valid_i = 1'b0; dec_valid_i = 1'b0; dec_bit_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; err_en_i = 1'b0; err_pat_i = 2'b00;
    src_valid_i = 1'b1; src_bit_i = 1'b1; dec_valid_i = 1'b0; dec_bit_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done_o); end
    total++; if (src_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", src_ready_o); end
    total++; if (enc_enable_o !== 1'b0) begin bad++; $display("FAIL reset_enable got=%0b want=0", enc_enable_o); end
    total++; if ({timeout_o, bit_err_o, inj_cnt_o, err_mask_o} !== 17'd0) begin
      bad++; $display("FAIL reset_counters got=%0b/%0d/%0d/%0d want=0", timeout_o, bit_err_o, inj_cnt_o, err_mask_o);
    end
    @(negedge clk);
    rst = 1'b0; src_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_frame();
    run_frame(1'b0, 2'b00, 1'b0, -1, -1, 1000, 0);
    total++; if (o_busy1 !== 1'b1) begin bad++; $display("FAIL clean_busy got=%0b want=1", o_busy1); end
    total++; if (o_n_en != FL + TL) begin bad++; $display("FAIL clean_n_en got=%0d want=%0d", o_n_en, FL + TL); end
    total++; if (o_first_en != 1 || o_last_en != FL + TL) begin
      bad++; $display("FAIL clean_en_span got=%0d..%0d want=1..%0d", o_first_en, o_last_en, FL + TL);
    end
    total++; if (o_en_bad != 0 || o_bit_bad != 0) begin
      bad++; $display("FAIL clean_enc got=%0d/%0d bad cycles want=0", o_en_bad, o_bit_bad);
    end
    total++; if (o_rdy_bad != 0) begin bad++; $display("FAIL clean_ready got=%0d bad cycles want=0", o_rdy_bad); end
    total++; if (o_done_cnt != 1 || o_done_cycle != 86) begin
      bad++; $display("FAIL clean_done got=%0d pulses at %0d want=1 at 86", o_done_cnt, o_done_cycle);
    end
    total++; if (bit_err_o !== 7'd0) begin bad++; $display("FAIL clean_bit_err got=%0d want=0", bit_err_o); end
    total++; if (inj_cnt_o !== 7'd0 || o_mask_bad != 0) begin
      bad++; $display("FAIL clean_inj got=%0d mask_bad=%0d want=0", inj_cnt_o, o_mask_bad);
    end
    total++; if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL clean_end got=timeout %0b busy %0b want=0 0", timeout_o, busy_o);
    end
  endtask

  task automatic test_injection();
    run_frame(1'b1, 2'b11, 1'b0, -1, -1, 1000, 0);
    total++; if (o_mask_bad != 0) begin bad++; $display("FAIL inj_mask got=%0d bad cycles want=0", o_mask_bad); end
    total++; if (o_inj != 4) begin bad++; $display("FAIL inj_seen got=%0d want=4", o_inj); end
    total++; if (inj_cnt_o !== 7'd4) begin bad++; $display("FAIL inj_cnt got=%0d want=4", inj_cnt_o); end
    total++; if (bit_err_o !== 7'd0) begin bad++; $display("FAIL inj_bit_err got=%0d want=0", bit_err_o); end
  endtask

  task automatic test_mismatch();
    // Zero pattern with injection on; a stray start during PAYLOAD must be ignored.
    run_frame(1'b1, 2'b00, 1'b0, 3, 40, 1000, 10);
    total++; if (bit_err_o !== 7'd2) begin bad++; $display("FAIL mis_bit_err got=%0d want=2", bit_err_o); end
    total++; if (inj_cnt_o !== 7'd0 || o_mask_bad != 0) begin
      bad++; $display("FAIL mis_zero_pat got=%0d mask_bad=%0d want=0", inj_cnt_o, o_mask_bad);
    end
    total++; if (o_n_en != FL + TL || o_en_bad != 0) begin
      bad++; $display("FAIL mis_restart got=%0d enables %0d bad want=%0d 0", o_n_en, o_en_bad, FL + TL);
    end
    total++; if (o_done_cnt != 1 || o_done_cycle != 86) begin
      bad++; $display("FAIL mis_done got=%0d pulses at %0d want=1 at 86", o_done_cnt, o_done_cycle);
    end
  endtask

  task automatic test_stall();
    run_frame(1'b0, 2'b00, 1'b1, -1, -1, 1000, 0);
    total++; if (o_en_bad != 0 || o_bit_bad != 0) begin
      bad++; $display("FAIL stall_enc got=%0d/%0d bad cycles want=0", o_en_bad, o_bit_bad);
    end
    total++; if (o_n_en != FL + TL) begin bad++; $display("FAIL stall_n_en got=%0d want=%0d", o_n_en, FL + TL); end
    total++; if (bit_err_o !== 7'd0) begin bad++; $display("FAIL stall_bit_err got=%0d want=0", bit_err_o); end
    total++; if (o_done_cnt != 1 || o_done_cycle != 149) begin
      bad++; $display("FAIL stall_done got=%0d pulses at %0d want=1 at 149", o_done_cnt, o_done_cycle);
    end
  endtask

  task automatic test_timeout();
    run_frame(1'b0, 2'b00, 1'b0, 3, 40, 10, 0);
    total++; if (o_done_cnt != 1 || o_done_cycle != 67 + TO) begin
      bad++; $display("FAIL to_done got=%0d pulses at %0d want=1 at %0d", o_done_cnt, o_done_cycle, 67 + TO);
    end
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_flag got=%0b want=1", timeout_o); end
    total++; if (bit_err_o !== 7'd1) begin bad++; $display("FAIL to_bit_err got=%0d want=1", bit_err_o); end
  endtask

  task automatic test_reset_mid_tail();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start_i = 1'b1; err_en_i = 1'b1; err_pat_i = 2'b01; src_valid_i = 1'b0; dec_valid_i = 1'b0;
    for (int c = 1; c <= FL + 1; c++) begin
      @(negedge clk);
      start_i = 1'b0; src_valid_i = 1'b1; src_bit_i = (c <= FL) ? pay_bit(c - 1) : 1'b1;
      #1;
      if (c == 1) begin
        total++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
          bad++; $display("FAIL rst_start_clear got=timeout %0b busy %0b want=0 1", timeout_o, busy_o);
        end
      end
    end
    total++; if (enc_enable_o !== 1'b1 || src_ready_o !== 1'b0 || enc_bit_o !== 1'b0) begin
      bad++; $display("FAIL rst_in_tail got=en %0b rdy %0b bit %0b want=1 0 0", enc_enable_o, src_ready_o, enc_bit_o);
    end
    total++; if (inj_cnt_o !== 7'd4) begin bad++; $display("FAIL rst_pre_inj got=%0d want=4", inj_cnt_o); end
    #2 rst = 1'b1;
    #1;
    total++; if ({busy_o, done_o, src_ready_o, enc_enable_o, enc_bit_o, err_mask_o} !== 7'd0) begin
      bad++; $display("FAIL rst_async_ctl got=%b want=0", {busy_o, done_o, src_ready_o, enc_enable_o, enc_bit_o, err_mask_o});
    end
    total++; if ({timeout_o, bit_err_o, inj_cnt_o} !== 15'd0) begin
      bad++; $display("FAIL rst_async_cnt got=%0b/%0d/%0d want=0", timeout_o, bit_err_o, inj_cnt_o);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (done_o === 1'b1) done_seen++;
    end
    rst = 1'b0; src_valid_i = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL rst_no_done got=%0d cycles want=0", done_seen); end
  endtask

  task automatic test_after_reset();
    run_frame(1'b0, 2'b00, 1'b0, -1, -1, 1000, 0);
    total++; if (o_done_cnt != 1 || o_done_cycle != 86 || o_n_en != FL + TL) begin
      bad++; $display("FAIL after_rst_frame got=%0d pulses at %0d, %0d enables want=1 at 86, %0d",
                      o_done_cnt, o_done_cycle, o_n_en, FL + TL);
    end
    total++; if (bit_err_o !== 7'd0 || inj_cnt_o !== 7'd0 || timeout_o !== 1'b0) begin
      bad++; $display("FAIL after_rst_counts got=%0d/%0d/%0b want=0", bit_err_o, inj_cnt_o, timeout_o);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_frame();
    test_injection();
    test_mismatch();
    test_stall();
    test_timeout();
    test_reset_mid_tail();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the convolutional-encoder / channel / Viterbi-decoder test path. Accepts payload bits from a source over a valid/ready handshake and drives the encoder enable and data. After the payload it appends zero tail bits to flush the trellis. It schedules channel error-injection masks, then scores the decoded bit stream against the stored payload and reports error counts per frame.

## Interface
Parameters:
- FRAME_LEN, 64: payload bits per frame (2..256).
- TAIL_LEN, 2: zero flush bits after payload (constraint length minus 1).
- ERR_LOG2, 4: error-injection period; inject on symbol index with low ERR_LOG2 bits all ones.
- TIMEOUT, 512: maximum cycles spent in DRAIN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle frame start request.
- err_en_i  in  1  enables error injection for the frame (sampled at start).
- err_pat_i  in  2  XOR pattern applied to the channel symbol pair on injection (sampled at start).
- src_valid_i  in  1  payload bit valid.
- src_bit_i  in  1  payload bit.
- src_ready_o  out  1  controller accepts a payload bit.
- enc_enable_o  out  1  encoder advance strobe.
- enc_bit_o  out  1  encoder input bit.
- err_mask_o  out  2  channel XOR mask, aligned with enc_enable_o.
- dec_valid_i  in  1  decoded bit strobe.
- dec_bit_i  in  1  decoded bit.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle end-of-frame pulse.
- timeout_o  out  1  frame ended by timeout (held until next start).
- bit_err_o  out  $clog2(FRAME_LEN+1)  decoded-bit mismatches in last frame.
- inj_cnt_o  out  $clog2(FRAME_LEN+TAIL_LEN+1)  symbols injected in last frame.

## Operation
- States: IDLE, PAYLOAD, TAIL, DRAIN, DONE.
- IDLE: start_i=1 → PAYLOAD. On the transition:
  - clear wr_idx, rd_idx, sym_idx, bit_err_o, inj_cnt_o and timeout_o;
  - latch err_en_i and err_pat_i.
- start_i in any other state is ignored.
- PAYLOAD:
  - src_ready_o=1.
  - On src_valid_i=1: enc_enable_o=1, enc_bit_o=src_bit_i, store the bit at payload[wr_idx], increment wr_idx and sym_idx.
  - With src_valid_i=0, enc_enable_o=0 (gap; no symbol issued).
  - After the transfer with wr_idx=FRAME_LEN-1 → TAIL.
- TAIL: src_ready_o=0, enc_enable_o=1, enc_bit_o=0 for exactly TAIL_LEN cycles, incrementing sym_idx. Then → DRAIN.
- Injection:
  - Applies in any cycle with enc_enable_o=1.
  - If err_en is latched and sym_idx[ERR_LOG2-1:0] is all ones: err_mask_o=err_pat (latched value) and inj_cnt_o increments (only if err_pat≠00).
  - Otherwise err_mask_o=00.
- Scoring runs in PAYLOAD, TAIL and DRAIN:
  - Each dec_valid_i with rd_idx<wr_idx compares dec_bit_i with payload[rd_idx]; a mismatch increments bit_err_o; rd_idx increments.
  - Strobes with rd_idx≥wr_idx (tail bits or surplus) are ignored.
- DRAIN:
  - The cycle counter starts at 0 on entry.
  - rd_idx reaching FRAME_LEN → DONE.
  - Counter reaching TIMEOUT-1 first → DONE with timeout_o=1.
- DONE: done_o=1 for one cycle → IDLE.
- bit_err_o, inj_cnt_o and timeout_o hold until the next accepted start.
- busy_o=1 in PAYLOAD, TAIL and DRAIN.
- Counters saturate at their maxima; this is unreachable with legal parameters.

## Timing
- Reset (async, active-high): state=IDLE; all outputs 0; payload store contents don't-care.
- All outputs are registered-state decodes, except:
  - enc_enable_o, enc_bit_o and src_ready_o are combinational from state and src_valid_i/src_bit_i;
  - err_mask_o is combinational from sym_idx and the latched configuration.
- Handshake: a transfer occurs on the cycle where src_valid_i & src_ready_o=1; no skid buffering.
- start_i high at edge t: PAYLOAD from t+1; the first transfer is possible in cycle t+1.
- Minimum encoder activity: FRAME_LEN+TAIL_LEN consecutive enable cycles when the source never stalls.
- A dec_valid_i in the same cycle as the final payload transfer is scored against the pre-increment wr_idx (strict rd_idx<wr_idx).
- done_o asserts the cycle after rd_idx reaches FRAME_LEN or the timeout fires; with both on the same cycle, timeout_o=0.
- Reset mid-frame aborts immediately to IDLE with no done_o.

## Test plan
- Clean frame: FRAME_LEN=64, err_en=0, source always valid, dec_bit echoes payload 20 cycles later → 66 consecutive enables, last 2 with bit 0; done_o; bit_err_o=0; inj_cnt_o=0; timeout_o=0.
- Injection: err_en=1, err_pat=11, ERR_LOG2=4, 66 symbols → err_mask_o=11 at sym_idx 15, 31, 47, 63; inj_cnt_o=4.
- Mismatches: decoder echo with bits 3 and 40 flipped → bit_err_o=2; extra tail strobes ignored.
- Source stalls: src_valid_i low on alternate cycles → enc_enable_o follows transfers only; bits stored in order; bit_err_o=0.
- Timeout: decoder emits only 10 strobes → DONE after 512 DRAIN cycles, timeout_o=1, bit_err_o reflects 10 compared bits.
- Control corners:
  - start_i pulsed during PAYLOAD → ignored;
  - rst asserted mid-TAIL → all outputs 0 asynchronously, IDLE, no done_o;
  - next start runs a clean frame.
